// File: rtl/frame_draw_ctrl.sv
// Per-frame drawing sequencer: runs the screen-clear engine, forwards its pixels to the
// VGA write port, then rasterises up to four black tiles (one per lane) and pulses frame_done.
module frame_draw_ctrl #(
    parameter int         AREA_X0    = 120,
    parameter int         LANE_W     = 20,
    parameter int         TILE_H     = 60,
    parameter int         MAX_Y      = 239,
    parameter logic [2:0] TILE_COLOR = 3'b000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_go,
    input  logic [3:0]  lane_valid,
    input  logic [31:0] lane_y,
    output logic        clr_go,
    input  logic [8:0]  clr_x,
    input  logic [7:0]  clr_y,
    input  logic [2:0]  clr_color,
    input  logic        clr_vga_en,
    input  logic        clr_done,
    output logic [8:0]  x,
    output logic [7:0]  y,
    output logic [2:0]  color,
    output logic        plot,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETUP,
        S_DRAW,
        S_DONE
    } state_t;

    state_t          r_state;
    logic            r_clr_go;
    logic [8:0]      r_x;
    logic [7:0]      r_y;
    logic [2:0]      r_color;
    logic            r_plot;
    logic            r_busy;
    logic            r_frame_done;

    logic [3:0]      r_snap_valid;
    logic [3:0][7:0] r_snap_y;
    logic [1:0]      r_lane;
    logic            r_seen_low;
    logic [8:0]      r_cx;
    logic [8:0]      r_cy;

    logic [7:0]      w_snap_y;
    logic [8:0]      w_x0;
    logic [8:0]      w_x1;
    logic [8:0]      w_ybot_raw;
    logic [8:0]      w_yb;
    logic            w_lane_live;

    // Tile geometry for the current lane; bottom row is computed in 9 bits so it cannot wrap.
    always_comb begin
        w_snap_y    = r_snap_y[r_lane];
        w_x0        = 9'(AREA_X0 + 1 + LANE_W * int'(r_lane));
        w_x1        = w_x0 + 9'(LANE_W - 3);
        w_ybot_raw  = {1'b0, w_snap_y} + 9'(TILE_H - 1);
        w_yb        = (w_ybot_raw > 9'(MAX_Y)) ? 9'(MAX_Y) : w_ybot_raw;
        w_lane_live = r_snap_valid[r_lane] && ({1'b0, w_snap_y} <= 9'(MAX_Y));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: snapshot, lane and cursor registers are left unreset; IDLE/SETUP always load them before use.
            r_state      <= S_IDLE;
            r_clr_go     <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_color      <= '0;
            r_plot       <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_plot <= 1'b0;
                    if (frame_go) begin
                        r_snap_valid <= lane_valid;
                        r_snap_y     <= lane_y;
                        r_lane       <= 2'd0;
                        r_clr_go     <= 1'b1;
                        r_seen_low   <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= S_CLEAR;
                    end
                end

                S_CLEAR: begin
                    r_x     <= clr_x;
                    r_y     <= clr_y;
                    r_color <= clr_color;
                    r_plot  <= clr_vga_en;
                    // A done is only trusted once it has been seen low with go held high.
                    if (!r_clr_go) begin
                        r_clr_go <= 1'b1;
                    end else if (clr_done) begin
                        r_clr_go <= 1'b0;
                        if (r_seen_low) begin
                            r_state <= S_SETUP;
                        end
                    end else begin
                        r_seen_low <= 1'b1;
                    end
                end

                S_SETUP: begin
                    r_plot <= 1'b0;
                    if (w_lane_live) begin
                        r_cx    <= w_x0;
                        r_cy    <= {1'b0, w_snap_y};
                        r_state <= S_DRAW;
                    end else if (r_lane == 2'd3) begin
                        r_frame_done <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_lane <= r_lane + 2'd1;
                    end
                end

                S_DRAW: begin
                    r_plot  <= 1'b1;
                    r_color <= TILE_COLOR;
                    r_x     <= r_cx;
                    r_y     <= r_cy[7:0];
                    if (r_cx == w_x1) begin
                        if (r_cy == w_yb) begin
                            if (r_lane == 2'd3) begin
                                r_frame_done <= 1'b1;
                                r_state      <= S_DONE;
                            end else begin
                                r_lane  <= r_lane + 2'd1;
                                r_state <= S_SETUP;
                            end
                        end else begin
                            r_cx <= w_x0;
                            r_cy <= r_cy + 9'd1;
                        end
                    end else begin
                        r_cx <= r_cx + 9'd1;
                    end
                end

                S_DONE: begin
                    r_plot  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign clr_go     = r_clr_go;
    assign x          = r_x;
    assign y          = r_y;
    assign color      = r_color;
    assign plot       = r_plot;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
